// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RISC-V style control FSM (optional MULTICYCLE_CTRL_PERF_EN retire counter)
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        funct7_5,
  input  logic        cero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        MEM_RD,
  output logic        MEM_WR,
  output logic        ir_we,
  output logic        pc_we,
  output logic        S_Mux_A,
  output logic [1:0]  S_Mux_B,
  output logic [1:0]  S_Mux_C,
  output logic [1:0]  control_ALU,
  output logic        REG_RD,
  output logic        REG_WR,
  output logic        trap,
  output logic [2:0]  state
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] instr_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  state_t     r_state;
  logic [6:0] r_opcode;
  logic       r_funct7_5;

  // Live decode is only consulted in DECODE; everything later uses the latched copy
  logic w_live_legal;
  logic w_live_lui;
  assign w_live_legal = (opcode == OP_BRANCH) || (opcode == OP_LUI)   ||
                        (opcode == OP_RTYPE)  || (opcode == OP_ITYPE) ||
                        (opcode == OP_STORE)  || (opcode == OP_LOAD);
  assign w_live_lui   = (opcode == OP_LUI);

  logic w_is_branch, w_is_lui, w_is_rtype, w_is_itype, w_is_store, w_is_load;
  assign w_is_branch = (r_opcode == OP_BRANCH);
  assign w_is_lui    = (r_opcode == OP_LUI);
  assign w_is_rtype  = (r_opcode == OP_RTYPE);
  assign w_is_itype  = (r_opcode == OP_ITYPE);
  assign w_is_store  = (r_opcode == OP_STORE);
  assign w_is_load   = (r_opcode == OP_LOAD);

  logic [1:0] w_mux_b;
  logic [1:0] w_alu;
  logic [1:0] w_mux_c_wb;
  assign w_mux_b    = (w_is_branch || w_is_lui)  ? 2'b11 :
                      w_is_store                 ? 2'b10 :
                      (w_is_itype || w_is_load)  ? 2'b01 : 2'b00;
  assign w_alu      = (w_is_branch || (w_is_rtype && r_funct7_5)) ? 2'b01 : 2'b00;
  assign w_mux_c_wb = w_is_lui  ? 2'b00 :
                      w_is_load ? 2'b10 : 2'b01;

  assign state = r_state;

  // State sequencing and instruction latch; stray codes fall back to FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_opcode   <= 7'b0000000;
      r_funct7_5 <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_opcode   <= opcode;
          r_funct7_5 <= funct7_5;
          r_state    <= w_live_legal ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          if (w_is_branch)                   r_state <= S_FETCH;
          else if (w_is_load || w_is_store)  r_state <= S_MEM;
          else                               r_state <= S_WB;
        end
        S_MEM:    if (mem_ready) r_state <= w_is_load ? S_WB : S_FETCH;
        S_WB:     r_state <= S_FETCH;
        S_TRAP:   r_state <= S_TRAP;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Output decode; gated by rst_n so an asserted reset kills every enable at once
  always_comb begin
    mem_req     = 1'b0;
    MEM_RD      = 1'b0;
    MEM_WR      = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    S_Mux_A     = 1'b0;
    S_Mux_B     = 2'b00;
    S_Mux_C     = 2'b11;
    control_ALU = 2'b00;
    REG_RD      = 1'b0;
    REG_WR      = 1'b0;
    trap        = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          MEM_RD  = 1'b1;
          ir_we   = mem_ready;
        end
        S_DECODE: REG_RD = !w_live_lui;
        S_EXEC: begin
          S_Mux_B     = w_mux_b;
          control_ALU = w_alu;
          if (w_is_branch) begin
            pc_we   = 1'b1;
            S_Mux_A = cero;
          end
        end
        S_MEM: begin
          S_Mux_B     = w_mux_b;
          control_ALU = w_alu;
          mem_req     = 1'b1;
          MEM_RD      = w_is_load;
          MEM_WR      = w_is_store;
          pc_we       = w_is_store && mem_ready;
        end
        S_WB: begin
          S_Mux_B     = w_mux_b;
          control_ALU = w_alu;
          S_Mux_C     = w_mux_c_wb;
          REG_WR      = 1'b1;
          pc_we       = 1'b1;
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] r_instr_count;
  assign instr_count = r_instr_count;

  // Retired-instruction counter, one tick per PC update, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_instr_count <= 32'd0;
    else if (pc_we) r_instr_count <= r_instr_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        funct7_5;
  logic        cero;
  logic        mem_ready;
  logic        mem_req, MEM_RD, MEM_WR, ir_we, pc_we, S_Mux_A;
  logic [1:0]  S_Mux_B, S_Mux_C, control_ALU;
  logic        REG_RD, REG_WR, trap;
  logic [2:0]  state;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] instr_count;
`endif

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct7_5(funct7_5),
    .cero(cero), .mem_ready(mem_ready), .mem_req(mem_req), .MEM_RD(MEM_RD),
    .MEM_WR(MEM_WR), .ir_we(ir_we), .pc_we(pc_we), .S_Mux_A(S_Mux_A),
    .S_Mux_B(S_Mux_B), .S_Mux_C(S_Mux_C), .control_ALU(control_ALU),
    .REG_RD(REG_RD), .REG_WR(REG_WR), .trap(trap), .state(state)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .instr_count(instr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [6:0]  op;
    logic        f7;
    logic        cero;
    logic        rdy;
    logic [17:0] exp;
  } cyc_t;

  cyc_t q[$];

  logic [17:0] act;
  assign act = {state, mem_req, MEM_RD, MEM_WR, ir_we, pc_we, S_Mux_A,
                S_Mux_B, S_Mux_C, control_ALU, REG_RD, REG_WR, trap};

  function automatic logic [17:0] ov(input logic [2:0] st, input logic mreq, input logic mrd,
                                     input logic mwr, input logic irwe, input logic pcwe,
                                     input logic ma, input logic [1:0] mb, input logic [1:0] mc,
                                     input logic [1:0] alu, input logic rrd, input logic rwr,
                                     input logic trp);
    return {st, mreq, mrd, mwr, irwe, pcwe, ma, mb, mc, alu, rrd, rwr, trp};
  endfunction

  localparam logic [17:0] RST_VEC = {3'd0, 6'b000000, 2'b00, 2'b11, 2'b00, 3'b000};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  task automatic check_vec(input string name, input logic [17:0] got, input logic [17:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got st=%0d req/rd/wr/ir/pc/A=%b B=%b C=%b alu=%b rrd/rwr/trap=%b expected st=%0d req/rd/wr/ir/pc/A=%b B=%b C=%b alu=%b rrd/rwr/trap=%b",
               name, got[17:15], got[14:9], got[8:7], got[6:5], got[4:3], got[2:0],
               exp[17:15], exp[14:9], exp[8:7], exp[6:5], exp[4:3], exp[2:0]);
    else n_pass++;
  endtask

  task automatic push(input logic [6:0] op, input logic f7, input logic c, input logic r,
                      input logic [17:0] e);
    cyc_t x;
    x.op = op; x.f7 = f7; x.cero = c; x.rdy = r; x.exp = e;
    q.push_back(x);
  endtask

  // Expand one instruction into its expected cycle-by-cycle schedule.
  // Outside DECODE the opcode/funct7_5 pins carry the complement, so any use
  // of live inputs after DECODE shows up as a wrong output.
  task automatic push_instr(input logic [6:0] op, input logic f7, input logic c,
                            input int fw, input int mw, input int ntrap);
    logic br, lui, rt, it, st, ld, legal;
    logic [1:0] mb, alu, mc;
    logic [6:0] junk;
    br  = (op == 7'b1100011);
    lui = (op == 7'b0110111);
    rt  = (op == 7'b0110011);
    it  = (op == 7'b0010011);
    st  = (op == 7'b0100011);
    ld  = (op == 7'b0000011);
    legal = br | lui | rt | it | st | ld;
    mb  = (br || lui) ? 2'b11 : st ? 2'b10 : (it || ld) ? 2'b01 : 2'b00;
    alu = (br || (rt && f7)) ? 2'b01 : 2'b00;
    mc  = lui ? 2'b00 : ld ? 2'b10 : 2'b01;
    junk = ~op;
    for (int i = 0; i < fw; i++)
      push(junk, ~f7, 1'b1, 1'b0, ov(3'd0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0, 0, 0));
    push(junk, ~f7, 1'b1, 1'b1, ov(3'd0, 1, 1, 0, 1, 0, 0, 2'b00, 2'b11, 2'b00, 0, 0, 0));
    push(op, f7, 1'b1, 1'b1, ov(3'd1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00, !lui, 0, 0));
    if (!legal) begin
      for (int i = 0; i < ntrap; i++)
        push(junk, ~f7, 1'b1, 1'b1, ov(3'd5, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0, 0, 1));
      return;
    end
    push(junk, ~f7, c, 1'b1, ov(3'd2, 0, 0, 0, 0, br, br & c, mb, 2'b11, alu, 0, 0, 0));
    if (st || ld) begin
      for (int i = 0; i < mw; i++)
        push(junk, ~f7, 1'b1, 1'b0, ov(3'd3, 1, ld, st, 0, 0, 0, mb, 2'b11, alu, 0, 0, 0));
      push(junk, ~f7, 1'b1, 1'b1, ov(3'd3, 1, ld, st, 0, st, 0, mb, 2'b11, alu, 0, 0, 0));
    end
    if (!br && !st)
      push(junk, ~f7, 1'b1, 1'b1, ov(3'd4, 0, 0, 0, 0, 1, 0, mb, mc, alu, 0, 1, 0));
  endtask

  // Single compare process: drive each scheduled cycle at negedge, check 1 ns later
  task automatic run_q(input int n);
    cyc_t c;
    for (int k = 0; k < n && q.size() > 0; k++) begin
      c = q.pop_front();
      @(negedge clk);
      opcode = c.op; funct7_5 = c.f7; cero = c.cero; mem_ready = c.rdy;
      #1;
      check_vec($sformatf("cyc_op%b_%0d", ~c.op, k), act, c.exp);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    check_vec({tag, "_in_reset"}, act, RST_VEC);
    @(negedge clk);
    #1;
    check_vec({tag, "_held_reset"}, act, RST_VEC);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    #1;
    check_vec({tag, "_first_fetch"}, act,
              ov(3'd0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0, 0, 0));
  endtask

  int cnt;

  initial begin
    rst_n = 1'b0; opcode = 7'b0; funct7_5 = 1'b0; cero = 1'b0; mem_ready = 1'b0;
    #3;
    check_vec("reset_async", act, RST_VEC);
    do_reset("rst0");

    // R-type sub, zero-wait memory; pin the model's state sequence
    push_instr(7'b0110011, 1'b1, 1'b0, 0, 0, 0);
    check("model_rtype_len", q.size(), 4);
    check("model_rtype_states", {q[0].exp[17:15], q[1].exp[17:15], q[2].exp[17:15], q[3].exp[17:15]},
          12'b000_001_010_100);
    check("model_rtype_exec_alu", q[2].exp[4:3], 2'b01);
    run_q(100);

    push_instr(7'b0110011, 1'b0, 1'b0, 2, 0, 0);
    push_instr(7'b0010011, 1'b1, 1'b0, 1, 0, 0);
    push_instr(7'b0110111, 1'b0, 1'b1, 0, 0, 0);
    run_q(100);

    // Load with three wait states
    push_instr(7'b0000011, 1'b0, 1'b0, 0, 3, 0);
    cnt = 0;
    foreach (q[i]) if (q[i].exp[17:15] == 3'd3) cnt++;
    check("model_load_mem_cycles", cnt, 4);
    check("model_load_wb_muxc", q[q.size()-1].exp[6:5], 2'b10);
    run_q(100);

    push_instr(7'b0100011, 1'b0, 1'b0, 1, 1, 0);
    run_q(100);

    // Branch taken then not taken
    push_instr(7'b1100011, 1'b0, 1'b1, 0, 0, 0);
    check("model_branch_taken", q[2].exp[10:9], 2'b11);
    push_instr(7'b1100011, 1'b1, 1'b0, 0, 0, 0);
    run_q(100);

    // Illegal opcode sits in TRAP until reset
    push_instr(7'b1111111, 1'b0, 1'b0, 0, 0, 10);
    run_q(100);
    do_reset("trap");

    // Reset during a stalled store
    push_instr(7'b0100011, 1'b0, 1'b0, 0, 5, 0);
    run_q(5);
    q.delete();
    do_reset("store_abort");

    // A normal instruction after the abort
    push_instr(7'b0010011, 1'b0, 1'b0, 0, 0, 0);
    run_q(100);

`ifdef MULTICYCLE_CTRL_PERF_EN
    do_reset("perf");
    push_instr(7'b0110011, 1'b1, 1'b0, 0, 0, 0);
    push_instr(7'b0010011, 1'b0, 1'b0, 0, 0, 0);
    push_instr(7'b0110111, 1'b0, 1'b0, 0, 0, 0);
    push_instr(7'b1100011, 1'b0, 1'b1, 0, 0, 0);
    push_instr(7'b0100011, 1'b0, 1'b0, 0, 1, 0);
    run_q(100);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("perf_count_5", instr_count, 32'd5);
    dut.r_instr_count = 32'hFFFF_FFFF;
    push_instr(7'b0110011, 1'b0, 1'b0, 0, 0, 0);
    run_q(100);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("perf_count_wrap", instr_count, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
